rd_pntrs_and_empty: RTL

Read-side pointer and status block of the dual-clock FIFO, the counterpart to the write-side pointer/full logic. It owns the binary and Gray read pointers, double-synchronises the write-side Gray pointer into the read clock domain, and produces registered empty, almost-empty and used-words status. It drives the FIFO memory read address and returns the Gray read pointer to the write domain.

---
 rtl/rd_pntrs_and_empty_if.sv | 35 +++
 rtl/rd_pntrs_and_empty.sv | 75 +++++++
 2 files changed

// File: rtl/rd_pntrs_and_empty_if.sv
// Read-side FIFO pointer bus: request and foreign write pointer in, read address,
// Gray read pointer and registered status out.
interface rd_pntrs_and_empty_if #(
  parameter int AWIDTH = 4
);
  logic              rd_req_i;
  logic [AWIDTH:0]   wr_pntr_gray_i;
  logic [AWIDTH-1:0] rd_pntr_o;
  logic [AWIDTH:0]   rd_pntr_gray_wr_o;
  logic              rd_empty_o;
  logic              rd_almost_empty_o;
  logic [AWIDTH:0]   rd_usedw_o;

  // Consumer / write-domain side
  modport master (
    output rd_req_i,
    output wr_pntr_gray_i,
    input  rd_pntr_o,
    input  rd_pntr_gray_wr_o,
    input  rd_empty_o,
    input  rd_almost_empty_o,
    input  rd_usedw_o
  );

  // Pointer block side
  modport slave (
    input  rd_req_i,
    input  wr_pntr_gray_i,
    output rd_pntr_o,
    output rd_pntr_gray_wr_o,
    output rd_empty_o,
    output rd_almost_empty_o,
    output rd_usedw_o
  );
endinterface

// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer and status logic of a dual-clock FIFO: binary/Gray read
// pointers, write-pointer synchroniser, registered empty/almost-empty/used-words.
module rd_pntrs_and_empty #(
  parameter int DWIDTH        = 8,
  parameter int AWIDTH        = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input logic                rd_clk_i,
  input logic                aclr_i,
  rd_pntrs_and_empty_if.slave bus
);

  localparam logic [AWIDTH:0] AE_LIMIT = (AWIDTH + 1)'(AEMPTY_THRESH);

  if (DWIDTH < 1 || AWIDTH < 1) begin : g_param_check
    $error("rd_pntrs_and_empty: DWIDTH and AWIDTH must be at least 1");
  end

  logic [AWIDTH:0] wr_sync1;
  logic [AWIDTH:0] wr_sync2;
  logic [AWIDTH:0] wr_bin_sync;
  logic [AWIDTH:0] rd_bin;
  logic [AWIDTH:0] rd_bin_next;
  logic [AWIDTH:0] rd_gray;
  logic [AWIDTH:0] rd_gray_next;
  logic [AWIDTH:0] usedw_next;
  logic [AWIDTH:0] rd_usedw;
  logic            rd_empty;
  logic            rd_almost_empty;
  logic            rd_en;

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional or
    // loop assignment, so no path can leave it unassigned and infer a latch.
    wr_bin_sync = '0;
    for (int i = 0; i <= AWIDTH; i++) begin
      wr_bin_sync[i] = ^(wr_sync2 >> i);
    end
    rd_en        = bus.rd_req_i & ~rd_empty;
    rd_bin_next  = rd_bin + (AWIDTH + 1)'(rd_en);
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    // Modulo subtraction: a full FIFO yields 2**AWIDTH thanks to the extra MSB
    usedw_next   = wr_bin_sync - rd_bin_next;
  end

  // Status looks ahead at rd_bin_next so the last read sets empty on its own edge
  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_sync1        <= '0;
      wr_sync2        <= '0;
      rd_bin          <= '0;
      rd_gray         <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_usedw        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; wr_sync2 must see the old wr_sync1 here.
      wr_sync1        <= bus.wr_pntr_gray_i;
      wr_sync2        <= wr_sync1;
      rd_bin          <= rd_bin_next;
      rd_gray         <= rd_gray_next;
      rd_empty        <= (rd_gray_next == wr_sync2);
      rd_almost_empty <= (usedw_next <= AE_LIMIT);
      rd_usedw        <= usedw_next;
    end
  end

  assign bus.rd_pntr_o         = rd_bin[AWIDTH-1:0];
  assign bus.rd_pntr_gray_wr_o = rd_gray;
  assign bus.rd_empty_o        = rd_empty;
  assign bus.rd_almost_empty_o = rd_almost_empty;
  assign bus.rd_usedw_o        = rd_usedw;

endmodule
